// File: rtl/dla_multi_walker_engine.sv
// ---------------------------------------------------------------------------
// dla_multi_walker_engine
//
// Diffusion-limited-aggregation engine. NUM_WALKERS random walkers take turns
// against a pixel framebuffer held in async SRAM, where bit DATA_W-1 of each
// word is the "occupied" flag. For each walker in turn the engine reads its
// 4 or 8 neighbours, then does one of three things:
//   - sticks the walker (writes its pixel) and respawns it near a corner,
//   - retries the same test if the SRAM window was lost part-way, or
//   - moves the walker one random step.
// The engine touches SRAM only while i_window is high. The top level muxes
// the SRAM address/WE between this engine (o_own=1) and the VGA scan-out.
//
// Ports
//   VGA_CTRL_CLK  in   clock
//   reset         in   synchronous, active-high
//   i_window      in   1 = engine may use SRAM this cycle
//   i_pause       in   1 = freeze the FSM, walkers and LFSRs
//   i_nbr8        in   0 = 4-neighbour test, 1 = 8-neighbour test
//   i_seed_x/y    in   seed pixel, sampled while reset=1
//   i_color       in   colour for stuck pixels (occupied bit forced on write)
//   i_sram_rdata  in   SRAM read data
//   o_sram_addr   out  SRAM address {x,y} (registered)
//   o_sram_wdata  out  SRAM write data (registered)
//   o_sram_we_n   out  active-low write enable (registered)
//   o_own         out  engine owns the SRAM bus this cycle (registered)
//   o_stuck_cnt   out  particles stuck since reset, saturating
//   o_lock_fail   out  tests aborted by window loss, saturating
// ---------------------------------------------------------------------------
module dla_multi_walker_engine #(
    parameter int          X_BITS      = 9,
    parameter int          Y_BITS      = 9,
    parameter int          X_MAX       = 319,
    parameter int          Y_MAX       = 239,
    parameter int          NUM_WALKERS = 4,
    parameter int          DATA_W      = 16,
    parameter logic [30:0] X_SEED      = 31'h55555555,
    parameter logic [28:0] Y_SEED      = 29'h15555555
) (
    input  logic                       VGA_CTRL_CLK,
    input  logic                       reset,
    input  logic                       i_window,
    input  logic                       i_pause,
    input  logic                       i_nbr8,
    input  logic [X_BITS-1:0]          i_seed_x,
    input  logic [Y_BITS-1:0]          i_seed_y,
    input  logic [DATA_W-1:0]          i_color,
    input  logic [DATA_W-1:0]          i_sram_rdata,
    output logic [X_BITS+Y_BITS-1:0]   o_sram_addr,
    output logic [DATA_W-1:0]          o_sram_wdata,
    output logic                       o_sram_we_n,
    output logic                       o_own,
    output logic [15:0]                o_stuck_cnt,
    output logic [15:0]                o_lock_fail
);

    localparam int W_BITS = (NUM_WALKERS > 1) ? $clog2(NUM_WALKERS) : 1;

    localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);
    localparam logic [X_BITS-1:0] X_LO  = X_BITS'(2);
    localparam logic [Y_BITS-1:0] Y_LO  = Y_BITS'(2);
    localparam logic [X_BITS-1:0] X_HI  = X_BITS'(X_MAX - 1);
    localparam logic [Y_BITS-1:0] Y_HI  = Y_BITS'(Y_MAX - 1);
    localparam logic [W_BITS-1:0] W_LAST = W_BITS'(NUM_WALKERS - 1);

    localparam logic [DATA_W-1:0] OCC_BIT = {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [2:0] ST_SEED    = 3'd0;
    localparam logic [2:0] ST_TEST    = 3'd1;
    localparam logic [2:0] ST_DECIDE  = 3'd2;
    localparam logic [2:0] ST_DRAW    = 3'd3;
    localparam logic [2:0] ST_RESPAWN = 3'd4;
    localparam logic [2:0] ST_MOVE    = 3'd5;

    logic [2:0]        state;
    logic [2:0]        k;          // neighbour index within the current test
    logic [W_BITS-1:0] w;          // walker under test
    logic              lock;       // window held continuously since TEST0
    logic              occ;        // OR of occupied flags sampled so far
    logic              nbr8_q;     // neighbourhood mode frozen for this test
    logic [30:0]       x_lfsr;
    logic [28:0]       y_lfsr;
    logic [X_BITS-1:0] seed_x;
    logic [Y_BITS-1:0] seed_y;
    logic [X_BITS-1:0] wx [NUM_WALKERS];
    logic [Y_BITS-1:0] wy [NUM_WALKERS];

    logic              active;
    logic              rdata_occ;
    logic [X_BITS-1:0] cur_x, nbr_x, move_x, spawn_x;
    logic [Y_BITS-1:0] cur_y, nbr_y, move_y, spawn_y;
    logic [2:0]        last_k;
    logic [W_BITS-1:0] w_next;
    logic              unused_rdata;

    assign active    = i_window & ~i_pause;
    assign rdata_occ = i_sram_rdata[DATA_W-1];
    assign cur_x     = wx[w];
    assign cur_y     = wy[w];
    // In TEST0 the mode register is not loaded yet, so use the live input.
    assign last_k    = ((k == 3'd0) ? i_nbr8 : nbr8_q) ? 3'd7 : 3'd3;
    assign w_next    = (w == W_LAST) ? '0 : w + W_BITS'(1);
    assign spawn_x   = x_lfsr[30] ? X_HI : X_LO;
    assign spawn_y   = y_lfsr[28] ? Y_HI : Y_LO;
    // Only the occupied flag matters here; the colour bits are don't-care.
    assign unused_rdata = ^i_sram_rdata[DATA_W-2:0];

    // Neighbour k of the current walker: L,R,U,D,UL,UR,DL,DR.
    // Walkers never leave [2,MAX-1], so these offsets cannot wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        nbr_x = cur_x;
        nbr_y = cur_y;
        case (k)
            3'd0: nbr_x = cur_x - X_ONE;
            3'd1: nbr_x = cur_x + X_ONE;
            3'd2: nbr_y = cur_y - Y_ONE;
            3'd3: nbr_y = cur_y + Y_ONE;
            3'd4: begin nbr_x = cur_x - X_ONE; nbr_y = cur_y - Y_ONE; end
            3'd5: begin nbr_x = cur_x + X_ONE; nbr_y = cur_y - Y_ONE; end
            3'd6: begin nbr_x = cur_x - X_ONE; nbr_y = cur_y + Y_ONE; end
            default: begin nbr_x = cur_x + X_ONE; nbr_y = cur_y + Y_ONE; end
        endcase
    end

    // One random step, clamped so the walker never reaches the screen edge.
    always_comb begin
        move_x = cur_x;
        move_y = cur_y;
        if (x_lfsr[30] && (cur_x < X_HI))
            move_x = cur_x + X_ONE;
        else if (!x_lfsr[30] && (cur_x > X_LO))
            move_x = cur_x - X_ONE;
        if (y_lfsr[28] && (cur_y < Y_HI))
            move_y = cur_y + Y_ONE;
        else if (!y_lfsr[28] && (cur_y > Y_LO))
            move_y = cur_y - Y_ONE;
    end

    always_ff @(posedge VGA_CTRL_CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // right-hand side sees the value from before this clock edge.
        if (reset) begin
            state        <= ST_SEED;
            k            <= '0;
            w            <= '0;
            lock         <= 1'b0;
            occ          <= 1'b0;
            nbr8_q       <= 1'b0;
            x_lfsr       <= X_SEED;
            y_lfsr       <= Y_SEED;
            seed_x       <= i_seed_x;
            seed_y       <= i_seed_y;
            // NOTE: the walker table is a handful of flops, not a RAM macro,
            // so it can be reset like any other register.
            for (int i = 0; i < NUM_WALKERS; i++) begin
                wx[i] <= X_BITS'(2 + 4 * i);
                wy[i] <= Y_LO;
            end
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
            o_sram_we_n  <= 1'b1;
            o_own        <= 1'b0;
            o_stuck_cnt  <= '0;
            o_lock_fail  <= '0;
        end else begin
            o_own       <= active;
            o_sram_we_n <= 1'b1;

            // Losing the window mid-test means a neighbour read may have hit
            // the VGA address instead, so the whole test must be redone.
            if (!i_window && ((state == ST_TEST) || (state == ST_DECIDE)))
                lock <= 1'b0;

            if (active) begin
                case (state)
                    ST_SEED: begin
                        o_sram_addr  <= {seed_x, seed_y};
                        o_sram_wdata <= i_color | OCC_BIT;
                        o_sram_we_n  <= 1'b0;
                        w            <= '0;
                        k            <= '0;
                        state        <= ST_TEST;
                    end

                    // Issue read k; the data now on the bus answers read k-1.
                    ST_TEST: begin
                        o_sram_addr <= {nbr_x, nbr_y};
                        if (k == 3'd0) begin
                            lock   <= 1'b1;
                            occ    <= 1'b0;
                            nbr8_q <= i_nbr8;
                        end else begin
                            occ <= occ | rdata_occ;
                        end
                        if (k == last_k)
                            state <= ST_DECIDE;
                        else
                            k <= k + 3'd1;
                    end

                    ST_DECIDE: begin
                        k <= '0;
                        if (!lock) begin
                            if (o_lock_fail != 16'hFFFF)
                                o_lock_fail <= o_lock_fail + 16'd1;
                            state <= ST_TEST;
                        end else if (occ | rdata_occ) begin
                            state <= ST_DRAW;
                        end else begin
                            state <= ST_MOVE;
                        end
                    end

                    ST_DRAW: begin
                        o_sram_addr  <= {cur_x, cur_y};
                        o_sram_wdata <= i_color | OCC_BIT;
                        o_sram_we_n  <= 1'b0;
                        if (o_stuck_cnt != 16'hFFFF)
                            o_stuck_cnt <= o_stuck_cnt + 16'd1;
                        state <= ST_RESPAWN;
                    end

                    ST_RESPAWN: begin
                        wx[w]  <= spawn_x;
                        wy[w]  <= spawn_y;
                        x_lfsr <= {x_lfsr[29:0], x_lfsr[30] ^ x_lfsr[27]};
                        y_lfsr <= {y_lfsr[27:0], y_lfsr[28] ^ y_lfsr[26]};
                        w      <= w_next;
                        state  <= ST_TEST;
                    end

                    ST_MOVE: begin
                        wx[w]  <= move_x;
                        wy[w]  <= move_y;
                        x_lfsr <= {x_lfsr[29:0], x_lfsr[30] ^ x_lfsr[27]};
                        y_lfsr <= {y_lfsr[27:0], y_lfsr[28] ^ y_lfsr[26]};
                        w      <= w_next;
                        state  <= ST_TEST;
                    end

                    default: state <= ST_SEED;
                endcase
            end
        end
    end

endmodule
